// File: rtl/mdu_pkg.sv
// Shared constants, op encodings and state type for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;
    localparam int unsigned MDU_CNT_W = $clog2(MDU_WIDTH);

    localparam logic [1:0] MDU_MULT  = 2'd0;
    localparam logic [1:0] MDU_MULTU = 2'd1;
    localparam logic [1:0] MDU_DIV   = 2'd2;
    localparam logic [1:0] MDU_DIVU  = 2'd3;

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} mdu_state_e;

    function automatic logic [MDU_WIDTH-1:0] mdu_abs(input logic [MDU_WIDTH-1:0] v,
                                                     input logic                 is_signed);
        return (is_signed && v[MDU_WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between a requester (master) and the MDU (slave).
interface mdu_if;
    import mdu_pkg::*;

    logic                 start;
    logic [1:0]           op;
    logic [MDU_WIDTH-1:0] A;
    logic [MDU_WIDTH-1:0] B;
    logic                 busy;
    logic                 done;
    logic [MDU_WIDTH-1:0] hi;
    logic [MDU_WIDTH-1:0] lo;
    logic                 div_by_zero;

    modport master (output start, op, A, B, input busy, done, hi, lo, div_by_zero);
    modport slave  (input start, op, A, B, output busy, done, hi, lo, div_by_zero);

endinterface

// File: rtl/mdu_step.sv
// One combinational radix-2 step: shift-add multiply, or restoring divide when MDU_DIV_EN
// is defined (otherwise the divide path and its mode select are omitted).
module mdu_step import mdu_pkg::*; (
`ifdef MDU_DIV_EN
    input  logic                   mode_div_i,
`endif
    input  logic [2*MDU_WIDTH-1:0] acc_i,
    input  logic [MDU_WIDTH-1:0]   opnd_i,
    output logic [2*MDU_WIDTH-1:0] acc_o,
    output logic                   q_bit_o
);
    localparam int unsigned W = MDU_WIDTH;

    logic [W:0] mul_sum;
`ifdef MDU_DIV_EN
    logic [W:0] div_shift;
    logic [W:0] div_diff;
`endif

    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier bits}
        mul_sum = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        acc_o   = {mul_sum, acc_i[W-1:1]};
        q_bit_o = 1'b0;
`ifdef MDU_DIV_EN
        div_shift = acc_i[2*W-1:W-1];
        div_diff  = div_shift - {1'b0, opnd_i};
        if (mode_div_i) begin
            // Divide: acc = {remainder, dividend bits shifting into quotient}
            q_bit_o = ~div_diff[W];
            acc_o   = {(q_bit_o ? div_diff[W-1:0] : div_shift[W-1:0]), acc_i[W-2:0], 1'b0};
        end
`endif
    end

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit, one radix-2 step per clock, HI/LO result with done
// pulse. Divide support is compiled in only when MDU_DIV_EN is defined.
module mdu_iterative import mdu_pkg::*; (
    input logic  clk,
    input logic  rst,
    mdu_if.slave bus
);
    localparam int unsigned W = MDU_WIDTH;

    mdu_state_e           state_q, state_d;
    logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]       acc_q, acc_d;
    logic [W-1:0]         opnd_q, opnd_d;
    logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;
    logic                 is_div_q, is_div_d, neg_q, neg_d, sign_a_q, sign_a_d;
    logic                 raw_q, raw_d, dz_q, dz_d;
    logic                 busy_q, busy_d, done_q, done_d, div_by_zero_q, div_by_zero_d;

    logic [2*W-1:0] step_acc, prod;
    logic           step_q_bit;
    logic [W-1:0]   a_mag, b_mag, quo, rem;
    logic           req_div, req_signed;

    mdu_step u_step (
`ifdef MDU_DIV_EN
        .mode_div_i (is_div_q),
`endif
        .acc_i      (acc_q),
        .opnd_i     (opnd_q),
        .acc_o      (step_acc),
        .q_bit_o    (step_q_bit)
    );

    always_comb begin
        req_div    = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
        req_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
        a_mag      = mdu_abs(bus.A, req_signed);
        b_mag      = mdu_abs(bus.B, req_signed);
        prod       = neg_q ? -acc_q : acc_q;
        quo        = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem        = sign_a_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        opnd_d        = opnd_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        is_div_d      = is_div_q;
        neg_d         = neg_q;
        sign_a_d      = sign_a_q;
        raw_d         = raw_q;
        dz_d          = dz_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        div_by_zero_d = div_by_zero_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    is_div_d      = req_div;
                    neg_d         = req_signed && (bus.A[W-1] ^ bus.B[W-1]);
                    sign_a_d      = req_signed && bus.A[W-1];
                    busy_d        = 1'b1;
                    div_by_zero_d = 1'b0;
                    raw_d         = 1'b0;
                    dz_d          = 1'b0;
                    cnt_d         = MDU_CNT_W'(W - 1);
                    state_d       = StRun;
                    if (!req_div) begin
                        acc_d  = {{W{1'b0}}, b_mag};
                        opnd_d = a_mag;
                    end else begin
`ifdef MDU_DIV_EN
                        acc_d  = {{W{1'b0}}, a_mag};
                        opnd_d = b_mag;
                        if (bus.B == '0) begin
                            // Raw result loaded verbatim in FIX, skipping iteration
                            acc_d   = {bus.A, {W{1'b1}}};
                            raw_d   = 1'b1;
                            dz_d    = 1'b1;
                            state_d = StFix;
                        end
`else
                        acc_d   = '0;
                        raw_d   = 1'b1;
                        state_d = StFix;
`endif
                    end
                end
            end
            StRun: begin
                acc_d = step_acc | {{(2*W-1){1'b0}}, step_q_bit};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (raw_q) begin
                    {hi_d, lo_d} = acc_q;
                end else if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    {hi_d, lo_d} = prod;
                end
                div_by_zero_d = dz_q;
                busy_d        = 1'b0;
                done_d        = 1'b1;
                state_d       = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            acc_q         <= '0;
            opnd_q        <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            is_div_q      <= 1'b0;
            neg_q         <= 1'b0;
            sign_a_q      <= 1'b0;
            raw_q         <= 1'b0;
            dz_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            opnd_q        <= opnd_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            is_div_q      <= is_div_d;
            neg_q         <= neg_d;
            sign_a_q      <= sign_a_d;
            raw_q         <= raw_d;
            dz_q          <= dz_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed cases plus random ops against an
// arithmetic reference model; honours MDU_DIV_EN the same way the design does.
module tb_mdu_iterative;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mdu_if bus ();

    mdu_iterative dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected HI/LO, divide-by-zero flag and start-to-done latency in clock edges.
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] hi,
                                      output logic [31:0] lo, output logic dz, output int lat);
        longint     sa;
        longint     sb;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        hi  = '0;
        lo  = '0;
        dz  = 1'b0;
        lat = 33;
        case (op)
            MDU_MULT: begin
                p = 64'(sa * sb);
                {hi, lo} = p;
            end
            MDU_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                {hi, lo} = p;
            end
            default: begin
`ifdef MDU_DIV_EN
                if (b == 0) begin
                    hi  = a;
                    lo  = '1;
                    dz  = 1'b1;
                    lat = 1;
                end else if (op == MDU_DIV) begin
                    lo = 32'(sa / sb);
                    hi = 32'(sa % sb);
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
`else
                lat = 1;
`endif
            end
        endcase
    endfunction

    // Issue one op; repulse_k >= 0 re-asserts start at the negedge after edge N+repulse_k.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int repulse_k);
        logic [31:0] e_hi, e_lo;
        logic        e_dz;
        int          e_lat;
        int          k;
        logic        seen;
        ref_model(op, a, b, e_hi, e_lo, e_dz, e_lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = $urandom();
        bus.B     = $urandom();
        check("busy_after_start", 64'(bus.busy), 64'(1));
        check("dz_cleared_on_start", 64'(bus.div_by_zero), 64'(0));
        k = 0;
        while (!bus.done && k < 60) begin
            if (k == repulse_k) begin
                bus.start = 1'b1;
                bus.op    = MDU_DIVU;
                bus.A     = 32'd1;
                bus.B     = 32'd0;
            end
            @(negedge clk);
            bus.start = 1'b0;
            k++;
        end
        check("latency", 64'(k), 64'(e_lat));
        check("busy_at_done", 64'(bus.busy), 64'(0));
        check("hi", 64'(bus.hi), 64'(e_hi));
        check("lo", 64'(bus.lo), 64'(e_lo));
        check("div_by_zero", 64'(bus.div_by_zero), 64'(e_dz));
        @(negedge clk);
        check("done_one_cycle", 64'(bus.done), 64'(0));
        check("hilo_hold", {bus.hi, bus.lo}, {e_hi, e_lo});
        if (repulse_k >= 0) begin
            seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                seen |= bus.done;
            end
            check("no_second_done", 64'(seen), 64'(0));
        end
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        logic        seen;

        bus.start = 1'b0;
        bus.op    = MDU_MULT;
        bus.A     = '0;
        bus.B     = '0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_hilo", {bus.hi, bus.lo}, 64'(0));
        check("rst_dz", 64'(bus.div_by_zero), 64'(0));
        rst = 1'b0;

        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op(MDU_MULT,  32'hFFFF_FFFD, 32'd5, -1);
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2, -1);
        run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op(MDU_DIVU,  32'd100, 32'd0, -1);
        run_op(MDU_MULTU, 32'd7, 32'd6, 4);
        run_op(MDU_MULT,  32'h1234_5678, 32'h9ABC_DEF0, -1);

        // Abort mid-run: rst sampled at edge N+10
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MDU_MULTU;
        bus.A     = 32'h1234_5678;
        bus.B     = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        check("abort_hilo", {bus.hi, bus.lo}, 64'(0));
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= bus.done;
        end
        check("abort_no_done", 64'(seen), 64'(0));
        run_op(MDU_MULTU, 32'd123456, 32'd654321, -1);

        for (int i = 0; i < 20; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom();
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom();
            endcase
            run_op(op, a, b, -1);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
